// File: rtl/if_unit_param.sv
// Instruction-fetch stage: fetch-address register, asynchronously read
// instruction memory with a write port, and the IF/ID pipeline register.
module if_unit_param #(
  parameter int                   PC_W      = 32,
  parameter int                   INSTR_W   = 32,
  parameter int                   MEM_DEPTH = 1024,
  parameter logic [PC_W-1:0]      RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = '0,
  localparam int                  AW        = $clog2(MEM_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               flush,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_addr,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr,
  output logic               valid,
  output logic               addr_fault
);

  localparam int UB = AW + 2;

  logic [INSTR_W-1:0] mem [MEM_DEPTH];

  logic [PC_W-1:0]    fa_q, fa_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               addr_fault_q, addr_fault_d;

  logic [PC_W-1:0]    fa_inc;
  logic [INSTR_W-1:0] rd_data;
  logic               out_of_range;

  assign fa_inc       = fa_q + PC_W'(4);
  assign rd_data      = mem[fa_q[AW+1:2]];
  // Any address bit above the word index means the fetch missed memory.
  assign out_of_range = |(fa_q >> UB);

  always_comb begin
    fa_d = fa_inc;
    if (rst)           fa_d = RESET_PC;
    else if (br_taken) fa_d = {br_addr[PC_W-1:2], 2'b00};
    else if (freeze)   fa_d = fa_q;
  end

  always_comb begin
    pc_d         = pc_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    addr_fault_d = addr_fault_q;
    if (rst || flush) begin
      pc_d         = '0;
      instr_d      = NOP_INSTR;
      valid_d      = 1'b0;
      addr_fault_d = 1'b0;
    end else if (!freeze) begin
      pc_d         = fa_inc;
      instr_d      = out_of_range ? NOP_INSTR : rd_data;
      valid_d      = !out_of_range;
      addr_fault_d = out_of_range;
    end
  end

  always_ff @(posedge clk) begin
    fa_q         <= fa_d;
    pc_q         <= pc_d;
    instr_q      <= instr_d;
    valid_q      <= valid_d;
    addr_fault_q <= addr_fault_d;
  end

  // Program port is unaffected by reset/stall; a same-cycle fetch sees old data.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  assign pc         = pc_q;
  assign instr      = instr_q;
  assign valid      = valid_q;
  assign addr_fault = addr_fault_q;

endmodule

// File: tb/tb_if_unit_param.sv
// Bench for if_unit_param: directed scenarios against fixed expectations plus
// a randomized run against a behavioural fetch-stage model.
module tb_if_unit_param;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, br_taken, prog_we;
  logic [31:0] br_addr, prog_data;
  logic [3:0]  prog_addr;
  logic [31:0] pc, instr;
  logic        valid, addr_fault;

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_fa, m_pc, m_instr;
  logic        m_valid, m_fault;

  if_unit_param #(.PC_W(32), .INSTR_W(32), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .br_taken(br_taken), .br_addr(br_addr), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .pc(pc), .instr(instr), .valid(valid), .addr_fault(addr_fault)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst = 0; freeze = 0; flush = 0; br_taken = 0; br_addr = '0;
    prog_we = 0; prog_addr = '0; prog_data = '0;
  endtask

  // One clock: model computes its next state from pre-edge values, then
  // the bench samples 1 time unit after the edge.
  task automatic tick();
    logic [31:0] n_fa, n_pc, n_instr;
    logic        n_v, n_f;
    if (rst)           n_fa = 32'h0;
    else if (br_taken) n_fa = br_addr & ~32'h3;
    else if (freeze)   n_fa = m_fa;
    else               n_fa = m_fa + 32'd4;
    n_pc = m_pc; n_instr = m_instr; n_v = m_valid; n_f = m_fault;
    if (rst || flush) begin
      n_pc = 0; n_instr = 0; n_v = 0; n_f = 0;
    end else if (!freeze) begin
      n_pc = m_fa + 32'd4;
      if (m_fa < DEPTH * 4) begin
        n_instr = m_mem[m_fa / 4]; n_v = 1; n_f = 0;
      end else begin
        n_instr = 0; n_v = 0; n_f = 1;
      end
    end
    if (prog_we) m_mem[prog_addr] = prog_data;
    @(posedge clk); #1;
    m_fa = n_fa; m_pc = n_pc; m_instr = n_instr; m_valid = n_v; m_fault = n_f;
  endtask

  task automatic test_reset();
    logic [65:0] exp;
    idle();
    rst = 1;
    for (int k = 0; k < DEPTH; k++) begin
      prog_we = 1; prog_addr = 4'(k);
      prog_data = (k < 4) ? 32'(17 * (k + 1)) : $urandom;
      tick();
    end
    idle(); rst = 1;
    tick();
    exp = {32'h0, 32'h0, 1'b0, 1'b0};
    vectors++;
    if ({pc, instr, valid, addr_fault} !== exp) begin
      miscompares++;
      $display("FAIL reset got %h expected %h", {pc, instr, valid, addr_fault}, exp);
    end
  endtask

  task automatic test_seq();
    logic [65:0] exp;
    idle();
    for (int k = 0; k < 4; k++) begin
      tick();
      exp = {32'(4 * (k + 1)), 32'(17 * (k + 1)), 1'b1, 1'b0};
      vectors++;
      if ({pc, instr, valid, addr_fault} !== exp) begin
        miscompares++;
        $display("FAIL seq[%0d] got %h expected %h", k, {pc, instr, valid, addr_fault}, exp);
      end
    end
  endtask

  task automatic test_freeze();
    logic [65:0] exp;
    idle(); rst = 1; tick();
    idle(); tick(); tick();
    freeze = 1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) freeze = 0;
      tick();
      exp = (k < 2) ? {32'd8, 32'h22, 1'b1, 1'b0} : {32'd12, 32'h33, 1'b1, 1'b0};
      vectors++;
      if ({pc, instr, valid, addr_fault} !== exp) begin
        miscompares++;
        $display("FAIL freeze[%0d] got %h expected %h", k, {pc, instr, valid, addr_fault}, exp);
      end
    end
  endtask

  task automatic test_branch_flush();
    logic [65:0] exp;
    idle(); br_taken = 1; br_addr = 32'h0E; flush = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      idle();
      exp = (k == 0) ? {32'd0, 32'h0, 1'b0, 1'b0} : {32'd16, 32'h44, 1'b1, 1'b0};
      vectors++;
      if ({pc, instr, valid, addr_fault} !== exp) begin
        miscompares++;
        $display("FAIL br_flush[%0d] got %h expected %h", k, {pc, instr, valid, addr_fault}, exp);
      end
    end
  endtask

  task automatic test_fault();
    logic [65:0] exp;
    idle(); br_taken = 1; br_addr = 32'h40; tick();
    idle(); tick();
    exp = {32'h44, 32'h0, 1'b0, 1'b1};
    vectors++;
    if ({pc, instr, valid, addr_fault} !== exp) begin
      miscompares++;
      $display("FAIL fault_set got %h expected %h", {pc, instr, valid, addr_fault}, exp);
    end
    br_taken = 1; br_addr = 32'h0; tick();
    idle(); tick();
    exp = {32'd4, 32'h11, 1'b1, 1'b0};
    vectors++;
    if ({pc, instr, valid, addr_fault} !== exp) begin
      miscompares++;
      $display("FAIL fault_clear got %h expected %h", {pc, instr, valid, addr_fault}, exp);
    end
  endtask

  task automatic test_write_collision();
    logic [65:0] exp;
    idle(); prog_we = 1; prog_addr = 4'd1; prog_data = 32'hAA; tick();
    exp = {32'd8, 32'h22, 1'b1, 1'b0};
    vectors++;
    if ({pc, instr, valid, addr_fault} !== exp) begin
      miscompares++;
      $display("FAIL wr_old got %h expected %h", {pc, instr, valid, addr_fault}, exp);
    end
    idle(); br_taken = 1; br_addr = 32'd4; flush = 1; tick();
    idle(); tick();
    exp = {32'd8, 32'hAA, 1'b1, 1'b0};
    vectors++;
    if ({pc, instr, valid, addr_fault} !== exp) begin
      miscompares++;
      $display("FAIL wr_new got %h expected %h", {pc, instr, valid, addr_fault}, exp);
    end
  endtask

  task automatic test_reset_override();
    logic [65:0] exp;
    idle(); rst = 1; freeze = 1; flush = 1; br_taken = 1; br_addr = 32'h20;
    tick();
    exp = {32'h0, 32'h0, 1'b0, 1'b0};
    vectors++;
    if ({pc, instr, valid, addr_fault} !== exp) begin
      miscompares++;
      $display("FAIL rst_override got %h expected %h", {pc, instr, valid, addr_fault}, exp);
    end
    idle(); tick();
    exp = {32'd4, 32'h11, 1'b1, 1'b0};
    vectors++;
    if ({pc, instr, valid, addr_fault} !== exp) begin
      miscompares++;
      $display("FAIL rst_refetch got %h expected %h", {pc, instr, valid, addr_fault}, exp);
    end
  endtask

  task automatic test_random();
    logic [65:0] exp;
    for (int k = 0; k < 400; k++) begin
      rst       = ($urandom_range(39) == 0);
      flush     = ($urandom_range(7) == 0);
      freeze    = ($urandom_range(4) == 0);
      br_taken  = ($urandom_range(7) == 0);
      br_addr   = ($urandom_range(9) == 0) ? $urandom : 32'($urandom_range(127));
      prog_we   = ($urandom_range(3) == 0);
      prog_addr = 4'($urandom_range(DEPTH - 1));
      prog_data = $urandom;
      tick();
      exp = {m_pc, m_instr, m_valid, m_fault};
      vectors++;
      if ({pc, instr, valid, addr_fault} !== exp) begin
        miscompares++;
        $display("FAIL random[%0d] got %h expected %h", k, {pc, instr, valid, addr_fault}, exp);
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_seq();
    test_freeze();
    test_branch_flush();
    test_fault();
    test_write_collision();
    test_reset_override();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
